// File: rtl/mips_debug_data_collector.sv
// mips_debug_data_collector
// Debug read-out source for the MIPS core. A one-cycle request code selects a
// register, data/instruction memory word, the PC or one 96-bit pipeline latch
// group. The selected data is streamed as 32-bit frames, MSB word first, and the
// transfer is closed with a one-cycle end-of-data strobe.
//
// Optional feature: define MIPS_DBG_COLLECT_STALL_EN to drive o_mips_stall as a
// registered copy of o_busy, freezing the core for the whole transfer. Without
// the macro o_mips_stall is tied low and the core free-runs during read-out.
//
// Handshake: there is no backpressure. A request is a single-cycle code on
// i_request_select (6'b111111 = none). It is accepted only while the FSM is
// IDLE; requests seen while busy, including the EOD cycle, are dropped. Each
// cycle with o_busy=1 and o_eod=0 carries exactly one valid word on o_frame.
module mips_debug_data_collector #(
  parameter int NB_DATA     = 32,
  parameter int NB_LATCH    = 96,
  parameter int NB_SELECT   = 6,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_MEM_ADDR = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_SELECT-1:0]    i_request_select,
  input  logic [NB_MEM_ADDR-1:0]  i_mem_addr,
  output logic [NB_REG_ADDR-1:0]  o_reg_rd_addr,
  input  logic [NB_DATA-1:0]      i_reg_rd_data,
  output logic [NB_MEM_ADDR-1:0]  o_dmem_rd_addr,
  input  logic [NB_DATA-1:0]      i_dmem_rd_data,
  input  logic [NB_DATA-1:0]      i_imem_rd_data,
  input  logic [NB_DATA-1:0]      i_pc,
  input  logic [8*NB_LATCH-1:0]   i_latch_bus,
  output logic [NB_DATA-1:0]      o_frame,
  output logic                    o_eod,
  output logic                    o_busy,
  output logic                    o_mips_stall,
  output logic [1:0]              o_dbg_state
);

  localparam logic [NB_SELECT-1:0] SEL_NONE      = 6'b111111;
  localparam logic [NB_SELECT-1:0] SEL_DMEM      = 6'b100000;
  localparam logic [NB_SELECT-1:0] SEL_IMEM      = 6'b100001;
  localparam logic [NB_SELECT-1:0] SEL_PC        = 6'b100010;
  localparam logic [NB_SELECT-1:0] SEL_LATCH_LO  = 6'b100100;
  localparam logic [NB_SELECT-1:0] SEL_LATCH_HI  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_EOD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_REG   = 3'd1,
    SRC_DMEM  = 3'd2,
    SRC_IMEM  = 3'd3,
    SRC_PC    = 3'd4,
    SRC_LATCH = 3'd5
  } src_t;

  state_t              state_q, state_d;
  src_t                src_q, src_d;
  logic [1:0]          cnt_q, cnt_d;     // index of the word currently on o_frame
  logic [1:0]          last_q, last_d;   // index of the final word (N-1)
  logic [NB_LATCH-1:0] shift_q, shift_d; // frozen latch snapshot, MSB word on top

  // Request decode: source, word count and selected latch group.
  src_t                req_src;
  logic [1:0]          req_words;
  logic [3:0]          grp_idx;
  logic [NB_LATCH-1:0] grp_data;

  // Memory/register read addresses follow the request directly so the
  // one-cycle read latency lines the data up with the first frame.
  assign o_reg_rd_addr  = i_request_select[NB_REG_ADDR-1:0];
  assign o_dmem_rd_addr = i_mem_addr;

  // Pick the 96-bit latch group addressed by the request (group 0 = MSB).
  assign grp_idx = i_request_select[3:0] - 4'd4;
  always_comb begin
    grp_data = '0;
    for (int g = 0; g < 8; g++) begin
      if (grp_idx[2:0] == g[2:0]) begin
        grp_data = i_latch_bus[8*NB_LATCH-1-NB_LATCH*g -: NB_LATCH];
      end
    end
  end

  // Classify the request code into a source and a word count.
  always_comb begin
    req_src   = SRC_NONE;
    req_words = 2'd0;
    if (!i_request_select[NB_SELECT-1]) begin
      req_src   = SRC_REG;
      req_words = 2'd1;
    end else if (i_request_select == SEL_DMEM) begin
      req_src   = SRC_DMEM;
      req_words = 2'd1;
    end else if (i_request_select == SEL_IMEM) begin
      req_src   = SRC_IMEM;
      req_words = 2'd1;
    end else if (i_request_select == SEL_PC) begin
      req_src   = SRC_PC;
      req_words = 2'd1;
    end else if ((i_request_select >= SEL_LATCH_LO) &&
                 (i_request_select <= SEL_LATCH_HI)) begin
      req_src   = SRC_LATCH;
      req_words = 2'd3;
    end
  end

  // Next-state logic: accept in IDLE, count words in SEND, one EOD cycle.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (i_request_select != SEL_NONE) begin
          src_d  = req_src;
          cnt_d  = 2'd0;
          last_d = req_words - 2'd1;
          if (req_src == SRC_LATCH) begin
            shift_d = grp_data;
          end
          state_d = (req_words == 2'd0) ? ST_EOD : ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == last_q) begin
          state_d = ST_EOD;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          shift_d = {shift_q[NB_LATCH-NB_DATA-1:0], {NB_DATA{1'b0}}};
        end
      end
      ST_EOD: begin
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in progress.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_NONE;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      shift_q <= shift_d;
    end
  end

  // Frame mux by stored source; zero outside SEND (including the EOD cycle).
  always_comb begin
    o_frame = '0;
    if (state_q == ST_SEND) begin
      case (src_q)
        SRC_REG:   o_frame = i_reg_rd_data;
        SRC_DMEM:  o_frame = i_dmem_rd_data;
        SRC_IMEM:  o_frame = i_imem_rd_data;
        SRC_PC:    o_frame = i_pc;
        SRC_LATCH: o_frame = shift_q[NB_LATCH-1 -: NB_DATA];
        default:   o_frame = '0;
      endcase
    end
  end

  assign o_eod       = (state_q == ST_EOD);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

`ifdef MIPS_DBG_COLLECT_STALL_EN
  logic stall_q;

  // Registered stall that tracks o_busy cycle for cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= (state_d != ST_IDLE);
    end
  end

  assign o_mips_stall = stall_q;
`else
  assign o_mips_stall = 1'b0;
`endif

endmodule
